// File: rtl/pipe_scroller.sv
// pipe_scroller
//   Generates and scrolls the three pipe obstacles of the playfield, counts
//   pipes that pass the box column as the score, and freezes everything when
//   the collision detector reports a hit.
//
//   Handshake: there is no valid/ready pairing here. start is a level whose
//   rising edge (start & ~start_q) is the only event consumed; collided is a
//   level sampled every cycle while in RUN.
//
//   Ports
//     CLOCK_50             in   system clock
//     reset                in   asynchronous, active-high reset
//     start                in   level from key; rising edge starts/restarts
//     collided             in   collision flag from the collision detector
//     pipe_x1..pipe_x3     out  8-bit pipe columns
//     pipe_y1..pipe_y3     out  7-bit gap top rows (gap spans y..y+30)
//     score                out  pipes passed, saturating at 255
//     running              out  high in RUN
//     state_dbg            out  FSM state (0 IDLE, 1 RUN, 2 HALT)
//
//   Optional feature macro: SPEEDUP_EN
//     Defined: the scroll period shrinks by TICK_DIV/16 per 8 points of
//     score, floored at TICK_DIV/4; the period is recomputed on each wrap.
//     Undefined: the scroll period is fixed at TICK_DIV.

module pipe_scroller #(
  parameter int SPACING  = 56,
  parameter int TICK_DIV = 833333,
  parameter int Y_MIN    = 10,
  parameter int BOX_X    = 4
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic       collided,
  output logic [7:0] pipe_x1,
  output logic [7:0] pipe_x2,
  output logic [7:0] pipe_x3,
  output logic [6:0] pipe_y1,
  output logic [6:0] pipe_y2,
  output logic [6:0] pipe_y3,
  output logic [7:0] score,
  output logic       running,
  output logic [1:0] state_dbg
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [CNT_W-1:0] TERM      = CNT_W'(TICK_DIV - 1);
  localparam logic [7:0]       INIT_X1   = 8'(2 * SPACING);
  localparam logic [7:0]       INIT_X2   = 8'(3 * SPACING);
  localparam logic [7:0]       INIT_X3   = 8'(4 * SPACING);
  localparam logic [7:0]       RELOAD_X  = 8'(3 * SPACING);
  localparam logic [6:0]       INIT_Y    = 7'(Y_MIN + 32);
  localparam logic [7:0]       BOX_COL   = 8'(BOX_X);
  localparam logic [7:0]       LFSR_SEED = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic             start_q, start_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0][7:0]  x_q, x_d;
  logic [2:0][6:0]  y_q, y_d;
  logic [7:0]       score_q, score_d;

  logic             start_edge;
  logic             step;
  logic             hit;
  logic [6:0]       reload_y;
  logic [CNT_W-1:0] period_m1;

`ifdef SPEEDUP_EN
  localparam int FLOOR_P = (TICK_DIV / 4 > 0) ? (TICK_DIV / 4) : 1;

  logic [CNT_W-1:0] period_m1_q, period_m1_d;
  int               period_calc;

  assign period_m1 = period_m1_q;
`else
  assign period_m1 = TERM;
`endif

  assign start_edge = start & ~start_q;
  // Gap top is Y_MIN plus the low six LFSR bits, so it never exceeds Y_MIN+63.
  assign reload_y   = 7'(Y_MIN) + {1'b0, lfsr_q[5:0]};

  always_comb begin
    // Fibonacci taps for x^8+x^6+x^5+x^4+1; the nonzero seed keeps it off zero.
    lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    start_d   = start;
    state_d   = state_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    y_d       = y_q;
    score_d   = score_q;
    step      = 1'b0;
    hit       = 1'b0;
`ifdef SPEEDUP_EN
    period_m1_d = period_m1_q;
    period_calc = 0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end

      ST_RUN: begin
        // Collision wins over a coincident tick so the pipes stay put.
        if (collided) begin
          state_d = ST_HALT;
        end else if (cnt_q >= period_m1) begin
          // ">=" also catches a period that shrank below the current count.
          cnt_d = '0;
          step  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_HALT: begin
        if (start_edge) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          score_d = '0;
          x_d[0]  = INIT_X1;
          x_d[1]  = INIT_X2;
          x_d[2]  = INIT_X3;
          y_d[0]  = INIT_Y;
          y_d[1]  = INIT_Y;
          y_d[2]  = INIT_Y;
`ifdef SPEEDUP_EN
          period_m1_d = TERM;
`endif
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (step) begin
      for (int i = 0; i < 3; i++) begin
        if (x_q[i] == BOX_COL) begin
          hit = 1'b1;
        end
        if (x_q[i] == 8'd0) begin
          x_d[i] = RELOAD_X;
          y_d[i] = reload_y;
        end else begin
          x_d[i] = x_q[i] - 8'd1;
        end
      end
      if (hit && (score_q != 8'hFF)) begin
        score_d = score_q + 8'd1;
      end
`ifdef SPEEDUP_EN
      period_calc = TICK_DIV - int'({27'd0, score_q[7:3]}) * (TICK_DIV / 16);
      if (period_calc < FLOOR_P) begin
        period_calc = FLOOR_P;
      end
      period_m1_d = CNT_W'(period_calc - 1);
`endif
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      lfsr_q  <= LFSR_SEED;
      start_q <= 1'b0;
      cnt_q   <= '0;
      x_q[0]  <= INIT_X1;
      x_q[1]  <= INIT_X2;
      x_q[2]  <= INIT_X3;
      y_q[0]  <= INIT_Y;
      y_q[1]  <= INIT_Y;
      y_q[2]  <= INIT_Y;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      score_q <= score_d;
    end
  end

`ifdef SPEEDUP_EN
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      period_m1_q <= TERM;
    end else begin
      period_m1_q <= period_m1_d;
    end
  end
`endif

  assign pipe_x1   = x_q[0];
  assign pipe_x2   = x_q[1];
  assign pipe_x3   = x_q[2];
  assign pipe_y1   = y_q[0];
  assign pipe_y2   = y_q[1];
  assign pipe_y3   = y_q[2];
  assign score     = score_q;
  assign running   = (state_q == ST_RUN);
  assign state_dbg = state_q;

endmodule
